// File: rtl/note_voice_alloc.sv
// note_voice_alloc: polyphonic voice allocator.
// Takes the note_on/note_off/note event stream and assigns each note to one
// of VOICES voice slots. Each event is scanned one voice per cycle and
// applied in a single commit cycle. One further event is buffered while busy.
// Optional feature macro: NOTE_VOICE_STEAL_EN. When it is defined, a note_on
// that finds neither a matching voice nor a free voice steals the oldest
// voice. When it is undefined, that note_on is dropped.
//
// state  | meaning
// IDLE   | waiting for an event strobe
// SCAN   | examining voice r_idx for match / free / oldest
// COMMIT | applying the latched event to the voice state

module note_voice_alloc #(
    parameter int VOICES = 4,
    parameter int AGE_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  note_on,
    input  logic                  note_off,
    input  logic [6:0]            note,
    output logic [7*VOICES-1:0]   voice_note,
    output logic [VOICES-1:0]     voice_gate,
    output logic [VOICES-1:0]     voice_trig,
    output logic                  busy,
    output logic                  drop
);

    localparam int IW = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [IW-1:0]    LAST_IDX = IW'(VOICES - 1);
    localparam logic [AGE_W-1:0] AGE_MAX  = '1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SCAN   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]       r_state;
    logic [IW-1:0]    r_idx;
    logic             r_ev_on;
    logic [6:0]       r_ev_note;
    logic             r_pend_vld;
    logic             r_pend_on;
    logic [6:0]       r_pend_note;

    logic             r_match_vld;
    logic [IW-1:0]    r_match_idx;
    logic             r_free_vld;
    logic [IW-1:0]    r_free_idx;

    logic [6:0]       r_note [VOICES];
    logic [AGE_W-1:0] r_age  [VOICES];
    logic [VOICES-1:0] r_gate;
    logic [VOICES-1:0] r_trig;
    logic             r_drop;

    logic             w_strobe;
    logic             w_first;
    logic             w_last;
    logic             w_cur_hit;
    logic             w_cur_free;
    logic             w_target_vld;
    logic [IW-1:0]    w_target_idx;
    logic             w_commit_on;

    assign w_strobe    = note_on | note_off;
    assign w_first     = (r_idx == '0);
    assign w_last      = (r_idx == LAST_IDX);
    assign w_cur_hit   = r_gate[r_idx] && (r_note[r_idx] == r_ev_note);
    assign w_cur_free  = !r_gate[r_idx];
    assign w_commit_on = (r_state == S_COMMIT) && r_ev_on;

`ifdef NOTE_VOICE_STEAL_EN
    logic             r_old_vld_unused_guard;
    logic [IW-1:0]    r_old_idx;
    logic [AGE_W-1:0] r_old_age;

    // Track the oldest voice; strict greater-than keeps the lowest index on ties.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_old_idx <= '0;
            r_old_age <= '0;
            r_old_vld_unused_guard <= 1'b0;
        end else if (r_state == S_SCAN) begin
            r_old_vld_unused_guard <= 1'b1;
            if (w_first || (r_age[r_idx] > r_old_age)) begin
                r_old_idx <= r_idx;
                r_old_age <= r_age[r_idx];
            end
        end
    end
`endif

    // Pick the commit target: retrigger a held note, else a free voice, else steal.
    always_comb begin
        w_target_vld = 1'b0;
        w_target_idx = '0;
        if (r_match_vld) begin
            w_target_vld = 1'b1;
            w_target_idx = r_match_idx;
        end else if (r_free_vld) begin
            w_target_vld = 1'b1;
            w_target_idx = r_free_idx;
        end else begin
`ifdef NOTE_VOICE_STEAL_EN
            w_target_vld = r_old_vld_unused_guard | 1'b1;
            w_target_idx = r_old_idx;
`else
            w_target_vld = 1'b0;
`endif
        end
    end

    // Sequencing FSM plus the one-deep pending event buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_ev_on     <= 1'b0;
            r_ev_note   <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_on   <= 1'b0;
            r_pend_note <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_strobe) begin
                        r_ev_on   <= note_on;
                        r_ev_note <= note;
                        r_idx     <= '0;
                        r_state   <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    r_idx <= r_idx + 1'b1;
                    if (w_last) begin
                        r_state <= S_COMMIT;
                    end
                    if (w_strobe && !r_pend_vld) begin
                        r_pend_vld  <= 1'b1;
                        r_pend_on   <= note_on;
                        r_pend_note <= note;
                    end
                end
                S_COMMIT: begin
                    r_idx <= '0;
                    if (r_pend_vld) begin
                        r_ev_on   <= r_pend_on;
                        r_ev_note <= r_pend_note;
                        r_state   <= S_SCAN;
                        if (w_strobe) begin
                            r_pend_on   <= note_on;
                            r_pend_note <= note;
                        end else begin
                            r_pend_vld <= 1'b0;
                        end
                    end else if (w_strobe) begin
                        // Pending slot is empty, so the strobe passes straight through it.
                        r_ev_on   <= note_on;
                        r_ev_note <= note;
                        r_state   <= S_SCAN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Track the lowest-index matching voice and lowest-index free voice.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_match_vld <= 1'b0;
            r_match_idx <= '0;
            r_free_vld  <= 1'b0;
            r_free_idx  <= '0;
        end else if (r_state == S_SCAN) begin
            if (w_cur_hit && (w_first || !r_match_vld)) begin
                r_match_vld <= 1'b1;
                r_match_idx <= r_idx;
            end else if (w_first) begin
                r_match_vld <= 1'b0;
            end
            if (w_cur_free && (w_first || !r_free_vld)) begin
                r_free_vld <= 1'b1;
                r_free_idx <= r_idx;
            end else if (w_first) begin
                r_free_vld <= 1'b0;
            end
        end
    end

    // Apply the committed event to the voice notes, gates and ages.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gate <= '0;
            for (int i = 0; i < VOICES; i++) begin
                r_note[i] <= '0;
                r_age[i]  <= '0;
            end
        end else if (r_state == S_COMMIT) begin
            for (int i = 0; i < VOICES; i++) begin
                if (r_ev_on) begin
                    if (w_target_vld) begin
                        if (i == int'(w_target_idx)) begin
                            r_note[i] <= r_ev_note;
                            r_gate[i] <= 1'b1;
                            r_age[i]  <= '0;
                        end else if (r_gate[i] && (r_age[i] != AGE_MAX)) begin
                            r_age[i] <= r_age[i] + 1'b1;
                        end
                    end
                end else if (r_gate[i] && (r_note[i] == r_ev_note)) begin
                    // Released voices keep their note for the envelope tail.
                    r_gate[i] <= 1'b0;
                end
            end
        end
    end

    // One-cycle trig and drop pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trig <= '0;
            r_drop <= 1'b0;
        end else begin
            r_trig <= '0;
            r_drop <= 1'b0;
            if (w_commit_on && w_target_vld) begin
                for (int i = 0; i < VOICES; i++) begin
                    if (i == int'(w_target_idx)) begin
                        r_trig[i] <= 1'b1;
                    end
                end
            end
            if ((r_state == S_SCAN) && w_strobe && r_pend_vld) begin
                r_drop <= 1'b1;
            end
            if (w_commit_on && !w_target_vld) begin
                r_drop <= 1'b1;
            end
        end
    end

    // Flatten per-voice notes onto the output bus.
    always_comb begin
        voice_note = '0;
        for (int i = 0; i < VOICES; i++) begin
            voice_note[7*i +: 7] = r_note[i];
        end
    end

    assign voice_gate = r_gate;
    assign voice_trig = r_trig;
    assign busy       = (r_state != S_IDLE);
    assign drop       = r_drop;

endmodule
